// File: rtl/arith_defs_pkg.sv
// rtl/arith_defs_pkg.sv - shared FSM encodings and sizing helpers for the serial adder
//
// Purpose : state encodings and counter-width helper used by serial_adder.
// Ports   : none (package).

package arith_defs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The bit counter must be able to hold SIZE itself, not just SIZE-1.
   function automatic int cnt_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/full_adder_1b.sv
// rtl/full_adder_1b.sv - single-bit combinational full adder cell
//
// Purpose : one full-adder bit, reused every cycle by serial_adder.
// Ports   : x, y, ci - operand bits and carry-in
//           s        - sum bit
//           co       - carry-out (majority of the three inputs)

module full_adder_1b (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, start/done handshake
//
// Purpose : computes {cout, sum} = a + b + cin one bit per clock using one
//           full-adder cell and a carry flop. Result held until next accept.
// Macro   : SERIAL_ADDER_OVERFLOW_EN adds the ovf output (signed overflow).
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           start          - begin an addition (accepted while ready=1)
//           a, b, cin      - operands, sampled on the accepting edge
//           ready          - high in IDLE and DONE
//           busy           - high while bits are being computed
//           done           - one-cycle pulse when sum/cout are valid
//           sum, cout      - registered result
//           ovf            - (optional) two's-complement overflow

module serial_adder
   import arith_defs_pkg::*;
#(
   parameter int SIZE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            cin,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] sum,
   output logic            cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic            ovf
`endif
);

   localparam int            CW       = cnt_width(SIZE);
   localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);

   state_t          r_state;
   state_t          w_next;
   logic [SIZE-1:0] r_a_sr;
   logic [SIZE-1:0] r_b_sr;
   logic [SIZE-1:0] r_sum;
   logic            r_carry;
   logic            r_cout;
   logic [CW-1:0]   r_cnt;

   logic            w_s;
   logic            w_c;
   logic            w_accept;
   logic            w_run;
   logic            w_last;
   logic [SIZE-1:0] w_sum_shift;

   full_adder_1b u_fa (
      .x  (r_a_sr[0]),
      .y  (r_b_sr[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_c)
   );

   // New sum bits enter at the MSB end so that after SIZE shifts bit 0
   // has reached position 0.
   generate
      if (SIZE == 1) begin : g_sum_one
         assign w_sum_shift = w_s;
      end else begin : g_sum_many
         assign w_sum_shift = {w_s, r_sum[SIZE-1:1]};
      end
   endgenerate

   assign w_accept = start & ready;
   assign w_run    = (r_state == ST_RUN);
   assign w_last   = w_run && (r_cnt == LAST_BIT);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_RUN;
         ST_RUN:  if (w_last) w_next = ST_DONE;
         ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (r_state)
         ST_IDLE: ready = 1'b1;
         ST_RUN:  busy  = 1'b1;
         ST_DONE: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   // Datapath: operand shift registers, carry, counter, sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a_sr  <= a;
         r_b_sr  <= b;
         r_sum   <= '0;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (w_run) begin
         r_a_sr  <= r_a_sr >> 1;
         r_b_sr  <= r_b_sr >> 1;
         r_sum   <= w_sum_shift;
         r_carry <= w_c;
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   // cout only changes when the final bit is computed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cout <= 1'b0;
      end else if (w_last) begin
         r_cout <= w_c;
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic r_ovf;

   // On the last bit r_carry is the carry into the MSB and w_c the carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= r_carry ^ w_c;
      end
   end

   assign ovf = r_ovf;
`endif

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at SIZE 1, 4 and 16

module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int          sel = 4;
   logic        t_start = 1'b0;
   logic [63:0] t_a = '0;
   logic [63:0] t_b = '0;
   logic        t_cin = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic        st1, st4, st16;
   logic [0:0]  a1, b1, sum1;
   logic [3:0]  a4, b4, sum4;
   logic [15:0] a16, b16, sum16;
   logic        ready1, busy1, done1, cout1;
   logic        ready4, busy4, done4, cout4;
   logic        ready16, busy16, done16, cout16;
`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic        ovf1, ovf4, ovf16, m_ovf;
`endif

   assign st1  = t_start & (sel == 1);
   assign st4  = t_start & (sel == 4);
   assign st16 = t_start & (sel == 16);
   assign a1   = t_a[0:0];
   assign b1   = t_b[0:0];
   assign a4   = t_a[3:0];
   assign b4   = t_b[3:0];
   assign a16  = t_a[15:0];
   assign b16  = t_b[15:0];

   serial_adder #(.SIZE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(t_cin),
      .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      , .ovf(ovf1)
`endif
   );

   serial_adder #(.SIZE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(t_cin),
      .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      , .ovf(ovf4)
`endif
   );

   serial_adder #(.SIZE(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .cin(t_cin),
      .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      , .ovf(ovf16)
`endif
   );

   logic        m_ready, m_busy, m_done, m_cout;
   logic [63:0] m_sum;

   always_comb begin
      m_ready = 1'b0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_cout  = 1'b0;
      m_sum   = '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      m_ovf   = 1'b0;
`endif
      case (sel)
         1: begin
            m_ready = ready1; m_busy = busy1; m_done = done1;
            m_cout = cout1; m_sum = 64'(sum1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
            m_ovf = ovf1;
`endif
         end
         4: begin
            m_ready = ready4; m_busy = busy4; m_done = done4;
            m_cout = cout4; m_sum = 64'(sum4);
`ifdef SERIAL_ADDER_OVERFLOW_EN
            m_ovf = ovf4;
`endif
         end
         16: begin
            m_ready = ready16; m_busy = busy16; m_done = done16;
            m_cout = cout16; m_sum = 64'(sum16);
`ifdef SERIAL_ADDER_OVERFLOW_EN
            m_ovf = ovf16;
`endif
         end
         default: m_sum = '0;
      endcase
   end

   // Starts one addition on the selected instance and waits (bounded) for done.
   // lat counts falling edges after the accepting edge up to the done cycle.
   task automatic do_add(input int sz, input logic [63:0] av, input logic [63:0] bv,
                         input logic cv, output int lat, output int busy_n);
      @(negedge clk);
      sel = sz; t_a = av; t_b = bv; t_cin = cv; t_start = 1'b1;
      @(negedge clk);
      t_start = 1'b0;
      t_a = {$urandom, $urandom};
      t_b = {$urandom, $urandom};
      t_cin = 1'($urandom);
      lat = 1;
      busy_n = m_busy ? 1 : 0;
      while (!m_done && lat < 200) begin
         @(negedge clk);
         lat++;
         if (m_busy) busy_n++;
      end
   endtask

   task automatic test_reset;
      n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", m_ready); end
      n_vec++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", m_busy); end
      n_vec++; if (m_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", m_done); end
      n_vec++; if (m_sum !== 64'd0) begin n_err++; $display("FAIL reset_sum got %0d want 0", m_sum); end
      n_vec++; if (m_cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", m_cout); end
   endtask

   task automatic test_directed;
      logic [3:0] va[3] = '{4'd5, 4'd15, 4'd15};
      logic [3:0] vb[3] = '{4'd3, 4'd1, 4'd15};
      logic       vc[3] = '{1'b0, 1'b0, 1'b1};
      logic [3:0] es[3] = '{4'd8, 4'd0, 4'd15};
      logic       ec[3] = '{1'b0, 1'b1, 1'b1};
      int lat, bn;
      for (int i = 0; i < 3; i++) begin
         do_add(4, 64'(va[i]), 64'(vb[i]), vc[i], lat, bn);
         n_vec++; if (lat != 5) begin n_err++; $display("FAIL dir%0d_latency got %0d want 5", i, lat); end
         n_vec++; if (bn != 4) begin n_err++; $display("FAIL dir%0d_busy_cycles got %0d want 4", i, bn); end
         n_vec++; if (m_sum !== 64'(es[i])) begin n_err++; $display("FAIL dir%0d_sum got %0d want %0d", i, m_sum, es[i]); end
         n_vec++; if (m_cout !== ec[i]) begin n_err++; $display("FAIL dir%0d_cout got %b want %b", i, m_cout, ec[i]); end
         n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_ready got %b want 1", i, m_ready); end
         @(negedge clk);
         n_vec++; if (m_done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width got %b want 0", i, m_done); end
         n_vec++; if (m_sum !== 64'(es[i])) begin n_err++; $display("FAIL dir%0d_sum_hold got %0d want %0d", i, m_sum, es[i]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] pa[3] = '{4'd3, 4'd10, 4'd12};
      logic [3:0] pb[3] = '{4'd4, 4'd5, 4'd9};
      logic       pc[3] = '{1'b0, 1'b1, 1'b0};
      logic [4:0] r;
      logic       exp_done;
      @(negedge clk);
      sel = 4; t_start = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i % 5 == 0) begin
            t_a = 64'(pa[i/5]); t_b = 64'(pb[i/5]); t_cin = pc[i/5];
         end else begin
            t_a = 64'($urandom); t_b = 64'($urandom); t_cin = 1'($urandom);
         end
         @(negedge clk);
         exp_done = (i % 5 == 4);
         n_vec++; if (m_done !== exp_done) begin n_err++; $display("FAIL b2b_done cyc%0d got %b want %b", i, m_done, exp_done); end
         n_vec++; if (m_busy !== !exp_done) begin n_err++; $display("FAIL b2b_busy cyc%0d got %b want %b", i, m_busy, !exp_done); end
         if (exp_done) begin
            r = 5'(pa[i/5]) + 5'(pb[i/5]) + 5'(pc[i/5]);
            n_vec++; if (m_sum !== 64'(r[3:0])) begin n_err++; $display("FAIL b2b_sum op%0d got %0d want %0d", i/5, m_sum, r[3:0]); end
            n_vec++; if (m_cout !== r[4]) begin n_err++; $display("FAIL b2b_cout op%0d got %b want %b", i/5, m_cout, r[4]); end
         end
      end
      t_start = 1'b0;
      @(negedge clk);
      n_vec++; if (m_done !== 1'b0 || m_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle got done=%b ready=%b want 0/1", m_done, m_ready); end
   endtask

   task automatic test_reset_abort;
      int lat, bn, seen;
      @(negedge clk);
      sel = 4; t_a = 64'd9; t_b = 64'd6; t_cin = 1'b1; t_start = 1'b1;
      @(negedge clk);
      t_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", m_busy); end
      n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", m_ready); end
      n_vec++; if (m_sum !== 64'd0) begin n_err++; $display("FAIL abort_sum got %0d want 0", m_sum); end
      n_vec++; if (m_cout !== 1'b0) begin n_err++; $display("FAIL abort_cout got %b want 0", m_cout); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_done) seen++;
      end
      n_vec++; if (seen != 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
      do_add(4, 64'd9, 64'd6, 1'b1, lat, bn);
      n_vec++; if (lat != 5) begin n_err++; $display("FAIL abort_next_latency got %0d want 5", lat); end
      n_vec++; if (m_sum !== 64'd0 || m_cout !== 1'b1) begin n_err++; $display("FAIL abort_next_result got sum=%0d cout=%b want 0/1", m_sum, m_cout); end
   endtask

`ifdef SERIAL_ADDER_OVERFLOW_EN
   task automatic test_overflow;
      logic [3:0] va[3] = '{4'd7, 4'd8, 4'd3};
      logic [3:0] vb[3] = '{4'd1, 4'd8, 4'd2};
      logic [3:0] es[3] = '{4'd8, 4'd0, 4'd5};
      logic       ec[3] = '{1'b0, 1'b1, 1'b0};
      logic       eo[3] = '{1'b1, 1'b1, 1'b0};
      int lat, bn;
      for (int i = 0; i < 3; i++) begin
         do_add(4, 64'(va[i]), 64'(vb[i]), 1'b0, lat, bn);
         n_vec++; if (m_sum !== 64'(es[i]) || m_cout !== ec[i]) begin n_err++; $display("FAIL ovf%0d_result got sum=%0d cout=%b want %0d/%b", i, m_sum, m_cout, es[i], ec[i]); end
         n_vec++; if (m_ovf !== eo[i]) begin n_err++; $display("FAIL ovf%0d_flag got %b want %b", i, m_ovf, eo[i]); end
      end
   endtask
`endif

   task automatic test_random;
      int          sizes[3] = '{1, 4, 16};
      int          counts[3] = '{334, 333, 333};
      int          sz, lat, bn;
      logic [63:0] mask, av, bv;
      logic        cv;
      logic [64:0] r;
      for (int k = 0; k < 3; k++) begin
         sz = sizes[k];
         mask = (64'd1 << sz) - 64'd1;
         for (int n = 0; n < counts[k]; n++) begin
            av = {$urandom, $urandom} & mask;
            bv = {$urandom, $urandom} & mask;
            cv = 1'($urandom);
            r  = 65'(av) + 65'(bv) + 65'(cv);
            do_add(sz, av, bv, cv, lat, bn);
            n_vec++; if (lat != sz + 1) begin n_err++; $display("FAIL rnd_latency sz%0d got %0d want %0d", sz, lat, sz + 1); end
            n_vec++; if (m_sum !== (r[63:0] & mask)) begin n_err++; $display("FAIL rnd_sum sz%0d %0d+%0d+%0d got %0d want %0d", sz, av, bv, cv, m_sum, r[63:0] & mask); end
            n_vec++; if (m_cout !== r[sz]) begin n_err++; $display("FAIL rnd_cout sz%0d %0d+%0d+%0d got %b want %b", sz, av, bv, cv, m_cout, r[sz]); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
            n_vec++;
            if (m_ovf !== ((av[sz-1] == bv[sz-1]) && (r[sz-1] != av[sz-1]))) begin
               n_err++; $display("FAIL rnd_ovf sz%0d %0d+%0d+%0d got %b", sz, av, bv, cv, m_ovf);
            end
`endif
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_directed;
      test_back_to_back;
      test_reset_abort;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      test_overflow;
`endif
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
